// File: rtl/hand_cricket_match_ctrl.sv
// -----------------------------------------------------------------------------
// hand_cricket_match_ctrl
//
// Two-innings match sequencer for hand_cricket_game. It holds the game in reset
// whenever no innings is live, counts balls, records the first-innings total,
// sets the chase target, ends the second innings on target reached, out or
// ball limit, and declares the winner.
//
// Parameters
//   MAX_BALLS   : balls per innings, 1..15
//
// Ports
//   clk         : system clock, rising edge
//   reset       : asynchronous, active-high match abort
//   start       : new-match request, honoured in IDLE and DONE only
//   play_strobe : game btn_play; one ball per clock it is high
//   score_in    : game leds (running score, unsigned)
//   out_in      : game out_flag
//   game_rst    : drives the game's reset; low only in INN1/INN2
//   state       : IDLE=0 INN1=1 BRK=2 INN2=3 DONE=4
//   innings     : 0 in the first innings, 1 from BRK onward
//   p1_score    : first-innings total
//   p2_score    : second-innings total, frozen at match end
//   target      : p1_score + 1 (9 bits, so 255 gives 256)
//   balls       : balls bowled in the current innings
//   winner      : 00 none, 01 P1, 10 P2, 11 tie
//   match_done  : high in DONE
// -----------------------------------------------------------------------------
module hand_cricket_match_ctrl #(
   parameter int unsigned MAX_BALLS = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       play_strobe,
   input  logic [7:0] score_in,
   input  logic       out_in,
   output logic       game_rst,
   output logic [2:0] state,
   output logic       innings,
   output logic [7:0] p1_score,
   output logic [7:0] p2_score,
   output logic [8:0] target,
   output logic [3:0] balls,
   output logic [1:0] winner,
   output logic       match_done
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_INN1 = 3'd1,
      ST_BRK  = 3'd2,
      ST_INN2 = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_P1   = 2'b01,
      WIN_P2   = 2'b10,
      WIN_TIE  = 2'b11
   } winner_t;

   localparam logic [3:0] MAX_B = 4'(MAX_BALLS);

   state_t      state_q,      state_d;
   winner_t     winner_q,     winner_d;
   logic        game_rst_q,   game_rst_d;
   logic        innings_q,    innings_d;
   logic [7:0]  p1_score_q,   p1_score_d;
   logic [7:0]  p2_score_q,   p2_score_d;
   logic [8:0]  target_q,     target_d;
   logic [3:0]  balls_q,      balls_d;
   logic        match_done_q, match_done_d;

   logic ball_ok;     // strobe that may still be counted (not saturated)
   logic limit_end;   // ball limit reached and the last score has settled
   logic innings_end; // out or limit ends the live innings this clock

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned; a missing default here would infer a latch.
      state_d      = state_q;
      winner_d     = winner_q;
      innings_d    = innings_q;
      p1_score_d   = p1_score_q;
      p2_score_d   = p2_score_q;
      target_d     = target_q;
      balls_d      = balls_q;

      ball_ok     = play_strobe && (balls_q != MAX_B);
      // The game updates score_in on the edge that samples the final strobe,
      // so the limit is judged on the first strobe-free clock after it.
      limit_end   = (balls_q == MAX_B) && !play_strobe;
      innings_end = out_in || limit_end;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d    = ST_INN1;
               innings_d  = 1'b0;
               balls_d    = '0;
               p1_score_d = '0;
               p2_score_d = '0;
               target_d   = '0;
               winner_d   = WIN_NONE;
            end
         end

         ST_INN1: begin
            if (innings_end) begin
               // Strobe on the ending clock is deliberately not counted.
               state_d    = ST_BRK;
               innings_d  = 1'b1;
               p1_score_d = score_in;
               target_d   = {1'b0, score_in} + 9'd1;
            end else if (ball_ok) begin
               balls_d = balls_q + 4'd1;
            end
         end

         ST_BRK: begin
            state_d = ST_INN2;
            balls_d = '0;
         end

         ST_INN2: begin
            p2_score_d = score_in;
            // Reaching the target outranks an out on the same clock.
            if ({1'b0, score_in} >= target_q) begin
               state_d  = ST_DONE;
               winner_d = WIN_P2;
            end else if (innings_end) begin
               state_d  = ST_DONE;
               winner_d = (score_in == p1_score_q) ? WIN_TIE : WIN_P1;
            end else if (ball_ok) begin
               balls_d = balls_q + 4'd1;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // Registered outputs derived from the next state so they line up with it.
      game_rst_d   = !((state_d == ST_INN1) || (state_d == ST_INN2));
      match_done_d = (state_d == ST_DONE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         winner_q     <= WIN_NONE;
         game_rst_q   <= 1'b1;
         innings_q    <= 1'b0;
         p1_score_q   <= '0;
         p2_score_q   <= '0;
         target_q     <= '0;
         balls_q      <= '0;
         match_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         winner_q     <= winner_d;
         game_rst_q   <= game_rst_d;
         innings_q    <= innings_d;
         p1_score_q   <= p1_score_d;
         p2_score_q   <= p2_score_d;
         target_q     <= target_d;
         balls_q      <= balls_d;
         match_done_q <= match_done_d;
      end
   end

   assign state      = state_q;
   assign winner     = winner_q;
   assign game_rst   = game_rst_q;
   assign innings    = innings_q;
   assign p1_score   = p1_score_q;
   assign p2_score   = p2_score_q;
   assign target     = target_q;
   assign balls      = balls_q;
   assign match_done = match_done_q;

endmodule

// File: tb/tb_hand_cricket_match_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hand_cricket_match_ctrl
//
// Self-checking bench for hand_cricket_match_ctrl (MAX_BALLS = 6). A short
// vector table walks one complete chase, hand-written sequences cover the
// ball limit, out, 255-run and asynchronous reset corners, and random matches
// are checked against an innings-level model of the rules of the game.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hand_cricket_match_ctrl;

   localparam int MAXB = 6;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       play_strobe;
   logic [7:0] score_in;
   logic       out_in;
   logic       game_rst;
   logic [2:0] state;
   logic       innings;
   logic [7:0] p1_score;
   logic [7:0] p2_score;
   logic [8:0] target;
   logic [3:0] balls;
   logic [1:0] winner;
   logic       match_done;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   hand_cricket_match_ctrl #(.MAX_BALLS(MAXB)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .play_strobe (play_strobe),
      .score_in    (score_in),
      .out_in      (out_in),
      .game_rst    (game_rst),
      .state       (state),
      .innings     (innings),
      .p1_score    (p1_score),
      .p2_score    (p2_score),
      .target      (target),
      .balls       (balls),
      .winner      (winner),
      .match_done  (match_done)
   );

   typedef struct {
      logic       start;
      logic       strobe;
      logic [7:0] score;
      logic       out;
      int         st;
      int         grst;
      int         inn;
      int         nb;   // -1 means balls is not compared on this row
      int         p1;
      int         p2;
      int         tgt;
      int         win;
      int         done;
   } vec_t;

   function automatic vec_t mk(input logic s, input logic pb, input logic [7:0] sc,
                               input logic o, input int st, input int grst,
                               input int inn, input int nb, input int p1,
                               input int p2, input int tgt, input int win,
                               input int done);
      vec_t v;
      v.start = s;  v.strobe = pb; v.score = sc; v.out = o;
      v.st = st;    v.grst = grst; v.inn = inn;  v.nb = nb;
      v.p1 = p1;    v.p2 = p2;     v.tgt = tgt;  v.win = win; v.done = done;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_all(input string nm, input int st, input int grst,
                            input int inn, input int nb, input int p1,
                            input int p2, input int tgt, input int win,
                            input int done);
      check({nm, ".state"},      32'(state),      st);
      check({nm, ".game_rst"},   32'(game_rst),   grst);
      check({nm, ".innings"},    32'(innings),    inn);
      if (nb >= 0) check({nm, ".balls"}, 32'(balls), nb);
      check({nm, ".p1_score"},   32'(p1_score),   p1);
      check({nm, ".p2_score"},   32'(p2_score),   p2);
      check({nm, ".target"},     32'(target),     tgt);
      check({nm, ".winner"},     32'(winner),     win);
      check({nm, ".match_done"}, 32'(match_done), done);
   endtask

   // Inputs change 1 ns after a rising edge; outputs are read at the same point.
   task automatic drive(input logic s, input logic pb, input logic [7:0] sc, input logic o);
      start       = s;
      play_strobe = pb;
      score_in    = sc;
      out_in      = o;
      @(posedge clk);
      #1;
   endtask

   // One random match. The expected totals come from walking the ball lists
   // with the rules of hand cricket; the driver then bowls exactly those balls.
   task automatic run_random_match(input int idx);
      int         r[2][6];
      bit         o[2][6];
      int         n[2];
      bit         was_out[2];
      bit         won;
      int         p1, p2, s, w;
      logic [7:0] sc;
      bit         ob;
      logic       end_strobe;
      string      nm;

      nm = $sformatf("rnd%0d", idx);
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 6; i++) begin
            r[k][i] = $urandom_range(0, 6);
            o[k][i] = ($urandom_range(0, 6) == 0);
         end

      // First innings: runs accumulate until an out or the last ball.
      s = 0; n[0] = 0; was_out[0] = 0;
      for (int i = 0; i < MAXB; i++) begin
         n[0]++;
         if (o[0][i]) begin was_out[0] = 1; break; end
         s += r[0][i];
      end
      p1 = s;

      // Second innings: passing p1 ends it at once; otherwise out or limit.
      s = 0; n[1] = 0; was_out[1] = 0; won = 0;
      for (int i = 0; i < MAXB; i++) begin
         n[1]++;
         if (o[1][i]) begin was_out[1] = 1; break; end
         s += r[1][i];
         if (s > p1) begin won = 1; break; end
      end
      p2 = s;
      w  = won ? 2 : ((p2 == p1) ? 3 : 1);

      drive(1'b1, 1'b0, 8'd0, 1'b0);
      check_all({nm, ".start"}, 1, 0, 0, 0, 0, 0, 0, 0, 0);

      for (int k = 0; k < 2; k++) begin
         sc = 8'd0;
         ob = 1'b0;
         for (int i = 0; i < n[k]; i++) begin
            repeat ($urandom_range(0, 1)) drive(1'($urandom_range(0, 1)), 1'b0, sc, 1'b0);
            drive(1'b0, 1'b1, sc, 1'b0);
            if (o[k][i]) ob = 1'b1;
            else         sc = sc + 8'(r[k][i]);
         end
         // A strobe on the ending clock must be ignored; at the limit the
         // ending clock is by definition strobe-free.
         end_strobe = (was_out[k] || (k == 1 && won)) ? 1'($urandom_range(0, 1)) : 1'b0;
         drive(1'b0, end_strobe, sc, ob);
         if (k == 0) begin
            check_all({nm, ".brk"}, 2, 1, 1, -1, p1, 0, p1 + 1, 0, 0);
            drive(1'b0, 1'b0, 8'd0, 1'b0);
            check_all({nm, ".inn2"}, 3, 0, 1, 0, p1, 0, p1 + 1, 0, 0);
         end else begin
            check_all({nm, ".done"}, 4, 1, 1, n[1], p1, p2, p1 + 1, w, 1);
            drive(1'b0, 1'b0, 8'd0, 1'b0);
            check_all({nm, ".hold"}, 4, 1, 1, n[1], p1, p2, p1 + 1, w, 1);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs[11];
      logic [7:0] ramp[6];

      // Chase succeeds at 10 against 9, with out_in high on the same clock,
      // then a restart straight from DONE. start in INN1 (row 2) is ignored.
      vecs[0]  = mk(1, 0,  0, 0, 1, 0, 0,  0, 0,  0,  0, 0, 0);
      vecs[1]  = mk(0, 1,  0, 0, 1, 0, 0,  1, 0,  0,  0, 0, 0);
      vecs[2]  = mk(1, 1,  3, 0, 1, 0, 0,  2, 0,  0,  0, 0, 0);
      vecs[3]  = mk(0, 0,  5, 0, 1, 0, 0,  2, 0,  0,  0, 0, 0);
      vecs[4]  = mk(0, 0,  9, 1, 2, 1, 1, -1, 9,  0, 10, 0, 0);
      vecs[5]  = mk(0, 0,  0, 0, 3, 0, 1,  0, 9,  0, 10, 0, 0);
      vecs[6]  = mk(0, 1,  0, 0, 3, 0, 1,  1, 9,  0, 10, 0, 0);
      vecs[7]  = mk(0, 1,  4, 0, 3, 0, 1,  2, 9,  4, 10, 0, 0);
      vecs[8]  = mk(0, 1, 10, 1, 4, 1, 1,  2, 9, 10, 10, 2, 1);
      vecs[9]  = mk(0, 0,  0, 0, 4, 1, 1,  2, 9, 10, 10, 2, 1);
      vecs[10] = mk(1, 0,  0, 0, 1, 0, 0,  0, 0,  0,  0, 0, 0);

      ramp[0] = 8'd0; ramp[1] = 8'd1; ramp[2] = 8'd2;
      ramp[3] = 8'd3; ramp[4] = 8'd5; ramp[5] = 8'd7;

      reset = 1'b1; start = 1'b0; play_strobe = 1'b0; score_in = 8'd0; out_in = 1'b0;
      #3;
      check_all("reset", 0, 1, 0, 0, 0, 0, 0, 0, 0);
      #9 reset = 1'b0;

      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].start, vecs[i].strobe, vecs[i].score, vecs[i].out);
         check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].grst, vecs[i].inn,
                   vecs[i].nb, vecs[i].p1, vecs[i].p2, vecs[i].tgt, vecs[i].win,
                   vecs[i].done);
      end

      // Seven strobes in INN1: the seventh is not counted.
      for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 8'(i), 1'b0);
      check_all("sat7", 1, 0, 0, 6, 0, 0, 0, 0, 0);
      drive(1'b0, 1'b0, 8'd9, 1'b0);
      check_all("lim1.brk", 2, 1, 1, -1, 9, 0, 10, 0, 0);
      drive(1'b0, 1'b0, 8'd0, 1'b0);
      check_all("lim1.inn2", 3, 0, 1, 0, 9, 0, 10, 0, 0);

      // Six balls in INN2 finishing level on 9: tie one clock after the sixth.
      for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, ramp[i], 1'b0);
      check_all("lim2.six", 3, 0, 1, 6, 9, 7, 10, 0, 0);
      drive(1'b0, 1'b0, 8'd9, 1'b0);
      check_all("lim2.tie", 4, 1, 1, 6, 9, 9, 10, 3, 1);

      // Out at 9 in INN1, out at 4 in INN2: P1 wins.
      drive(1'b1, 1'b0, 8'd0, 1'b0);
      drive(1'b0, 1'b1, 8'd0, 1'b0);
      drive(1'b0, 1'b0, 8'd9, 1'b1);
      check_all("out.brk", 2, 1, 1, -1, 9, 0, 10, 0, 0);
      drive(1'b0, 1'b0, 8'd0, 1'b0);
      check_all("out.inn2", 3, 0, 1, 0, 9, 0, 10, 0, 0);
      drive(1'b0, 1'b1, 8'd0, 1'b0);
      drive(1'b0, 1'b1, 8'd2, 1'b0);
      drive(1'b0, 1'b0, 8'd4, 1'b1);
      check_all("out.p1win", 4, 1, 1, 2, 9, 4, 10, 1, 1);

      // 255 in INN1: target 256 cannot be chased, 255 is only a tie.
      drive(1'b1, 1'b0, 8'd0, 1'b0);
      drive(1'b0, 1'b0, 8'd255, 1'b1);
      check_all("max.brk", 2, 1, 1, -1, 255, 0, 256, 0, 0);
      drive(1'b0, 1'b0, 8'd0, 1'b0);
      drive(1'b0, 1'b1, 8'd255, 1'b0);
      check_all("max.nochase", 3, 0, 1, 1, 255, 255, 256, 0, 0);
      drive(1'b0, 1'b0, 8'd255, 1'b1);
      check_all("max.tie", 4, 1, 1, 1, 255, 255, 256, 3, 1);

      // Asynchronous abort in INN2 with three balls bowled.
      drive(1'b1, 1'b0, 8'd0, 1'b0);
      drive(1'b0, 1'b0, 8'd5, 1'b1);
      drive(1'b0, 1'b0, 8'd0, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'(i), 1'b0);
      check_all("abort.pre", 3, 0, 1, 3, 5, 2, 6, 0, 0);
      #2 reset = 1'b1;
      #1;
      check_all("abort.async", 0, 1, 0, 0, 0, 0, 0, 0, 0);
      #2 reset = 1'b0;
      drive(1'b0, 1'b1, 8'd3, 1'b0);
      check_all("abort.idle", 0, 1, 0, 0, 0, 0, 0, 0, 0);

      for (int m = 0; m < 40; m++) run_random_match(m);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hand_cricket_match_ctrl.md
# hand_cricket_match_ctrl

Two-innings match sequencer sitting directly downstream of `hand_cricket_game`. It consumes the game's running score (`leds`) and `out_flag` and drives the game's `reset` so each player bats one innings. It records the first-innings total, sets the chase target, ends the second innings on out, on target reached, or on ball limit, and declares the winner.

## Interface
- `MAX_BALLS`, default 6: balls per innings; valid range 1..15.
- `clk` input 1: system clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high; forces IDLE and the reset values listed below.
- `start` input 1: request a new match; sampled in IDLE and DONE only.
- `play_strobe` input 1: same signal as the game's `btn_play`; one ball is counted per clock it is high.
- `score_in` input 8: connects to the game's `leds`; unsigned running score.
- `out_in` input 1: connects to the game's `out_flag`.
- `game_rst` output 1: drives the game's `reset`.
- `state` output 3: IDLE=0, INN1=1, BRK=2, INN2=3, DONE=4.
- `innings` output 1: 0 during the first innings, 1 from BRK onward.
- `p1_score` output 8: first-innings total.
- `p2_score` output 8: second-innings total, frozen at match end.
- `target` output 9: `p1_score`+1.
- `balls` output 4: balls bowled in the current innings.
- `winner` output 2: 00 none, 01 P1, 10 P2, 11 tie.
- `match_done` output 1: high in DONE.

## Operation
- All outputs are registered. Reset values:
  - `state`=IDLE and `game_rst`=1.
  - `innings`, `p1_score`, `p2_score`, `target`, `balls`, `winner` and `match_done` are all 0.
- `game_rst`=1 in IDLE, BRK and DONE; 0 in INN1 and INN2. The game is therefore frozen and cleared whenever no innings is live.
- IDLE: on `start`=1 go to INN1. At the same time clear `balls`, `p1_score`, `p2_score`, `target` and `winner`.
- INN1 and INN2, ball counting:
  - `balls` increments on each clock where `play_strobe`=1.
  - `balls` saturates at `MAX_BALLS`; strobes beyond that are ignored.
- INN1 ends when `out_in`=1, or when `balls`==`MAX_BALLS` and `play_strobe`=0. On that clock:
  - `p1_score`←`score_in` and `target`←`score_in`+1, computed in 9 bits so 255 gives 256.
  - Go to BRK.
- BRK lasts exactly one clock, with `game_rst` high. It clears `balls` and sets `innings`=1, then goes to INN2.
- INN2: `p2_score` tracks `score_in` every clock. End checks, in priority order:
  1. {1'b0,`score_in`}>=`target`: `winner`=10 and go to DONE. This wins even if `out_in`=1 on the same clock.
  2. `out_in`=1, or `balls`==`MAX_BALLS` with `play_strobe`=0:
     - `winner`=11 if `score_in`==`p1_score`, otherwise 01.
     - Go to DONE.
- DONE: holds all results; `match_done`=1. On `start`=1 go to INN1 and clear results exactly as in IDLE.
- `start` is ignored in INN1, BRK and INN2.
- `play_strobe` is ignored outside INN1 and INN2.
- An asserted `reset` in any state aborts the match immediately, asynchronously, to the reset values.

## Timing
- `start` high at edge N: `state`=INN1 and `game_rst`=0 after edge N. The first strobe the game can accept is at edge N+1.
- Score latency: the game updates `leds` on the edge that samples `btn_play`. The controller therefore judges ball-limit end one clock after the final strobe, when `score_in` is valid. Out end is judged on the first clock `out_in` is seen high.
- From the INN1 end condition to INN2: 2 edges (INN1→BRK→INN2).
- `winner` and `match_done` update on the same edge as entry to DONE.
- A strobe on the same clock as the out or limit condition is not counted.
- A back-to-back `start` in DONE restarts without passing through IDLE.

## Test plan
- Reset mid-INN2 with `balls`=3: all outputs return to their reset values asynchronously, before the next edge; `game_rst`=1.
- INN1 ends by out at `score_in`=9: `p1_score`=9, `target`=10, BRK visible for 1 clock with `game_rst`=1, then INN2.
- Chase succeeds: `p1_score`=9, `score_in` reaches 10 in INN2 → `winner`=10, `match_done`=1; simultaneous `out_in`=1 still gives 10.
- Ball limit, `MAX_BALLS`=6: six strobes in INN2 ending at `score_in`=9 against `p1_score`=9 → `winner`=11, one clock after the sixth strobe; a seventh strobe is not counted (`balls` stays 6).
- Out in INN2 at `score_in`=4 against `p1_score`=9 → `winner`=01.
- `p1_score`=255 → `target`=256; INN2 cannot chase (max 255), and the match ends 01 or 11 only.
- `start` pulsed during INN1 is ignored; `start` in DONE → INN1 next clock with results cleared.
